// File: rtl/uart_tx.sv
// Purpose : UART transmitter; one byte per request, framed as start, 8 data bits MSB first, parity, stop.
// Latency : tx falls on the same edge that samples tx_start; tx_done pulses 11*CLKS_PER_BIT clocks later.
// Backpr. : none; tx_start is ignored while a frame is in flight, so callers pace themselves on tx_done.
//
// Ports:
//   clk_3125    - 3.125 MHz system clock, all state on its rising edge
//   rst_n       - synchronous active-low reset; aborts any frame in progress
//   parity_type - 0 = even parity, 1 = odd parity (latched at frame start)
//   tx_start    - frame request, acted on only in IDLE
//   data        - payload byte (latched at frame start)
//   tx          - registered serial line, idles high
//   tx_done     - registered one-cycle pulse on the edge that ends the stop bit
module uart_tx #(
    parameter int CLKS_PER_BIT = 14,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_3125,
    input  logic                 rst_n,
    input  logic                 parity_type,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 tx_done
);

    // Counter widths, guarded so a degenerate parameter never yields a zero-width vector.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cyc_cnt;
    logic [CNT_W-1:0]     cyc_nxt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_nxt;
    logic                 load_shadow;
    logic                 bit_end;

    // Shadow copies of the request; the live inputs are free to change mid-frame.
    logic [DATA_BITS-1:0] shadow_dat;
    logic                 shadow_par;
    logic                 par_bit;

    logic                 tx_nxt;
    logic                 done_nxt;

    // Last clock of the current serial bit.
    assign bit_end = (cyc_cnt == CNT_LAST);

    // Even parity is the plain XOR of the payload; odd parity inverts it.
    assign par_bit = (^shadow_dat) ^ shadow_par;

    // ------------------------------------------------------------------
    // State register. tx and tx_done are registered here as well so the
    // pin never sees a combinational path from the inputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_3125) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shadow_dat <= '0;
            shadow_par <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            tx      <= tx_nxt;
            tx_done <= done_nxt;
            if (load_shadow) begin
                shadow_dat <= data;
                shadow_par <= parity_type;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Every state lasts CLKS_PER_BIT edges: the cycle
    // counter runs 0..CNT_LAST and the state advances on CNT_LAST.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        cyc_nxt     = cyc_cnt;
        bit_nxt     = bit_cnt;
        load_shadow = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    state_nxt   = S_START;
                    cyc_nxt     = '0;
                    bit_nxt     = '0;
                    load_shadow = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                end else begin
                    cyc_nxt = cyc_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cyc_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = S_PARITY;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    cyc_nxt = cyc_cnt + CNT_W'(1);
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc_cnt + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    state_nxt = S_IDLE;
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                end else begin
                    cyc_nxt = cyc_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cyc_nxt   = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The line value is decoded from the state being entered,
    // so the register loads the new bit on exactly the edge the state
    // changes and tx is stable for the whole bit period. On the IDLE->START
    // edge the shadow registers are not loaded yet, which is fine because
    // START only needs a constant 0.
    // ------------------------------------------------------------------
    always_comb begin
        tx_nxt   = 1'b1;
        done_nxt = 1'b0;

        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shadow_dat[BIT_LAST - bit_nxt];   // MSB first
            S_PARITY: tx_nxt = par_bit;
            default:  tx_nxt = 1'b1;                             // IDLE, STOP
        endcase

        // The edge that ends the stop bit is the frame-complete edge.
        done_nxt = (state == S_STOP) && bit_end;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Purpose : stand-alone bench for uart_tx; random and directed frames against a bit-level frame model.
// Latency : frame model expects tx low on the request edge and tx_done 154 clocks later.
// Backpr. : n/a; bench paces requests on the frame length.
module tb_uart_tx;

    localparam int CPB   = 14;
    localparam int NBITS = 11;
    localparam int FLEN  = NBITS * CPB;

    logic       clk_3125;
    logic       rst_n;
    logic       parity_type;
    logic       tx_start;
    logic [7:0] data;
    logic       tx;
    logic       tx_done;

    int n_chk;
    int n_fail;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .parity_type (parity_type),
        .tx_start    (tx_start),
        .data        (data),
        .tx          (tx),
        .tx_done     (tx_done)
    );

    initial clk_3125 = 1'b0;
    always #5 clk_3125 = ~clk_3125;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at time %0t", tag, obs, exp, $time);
        end
    endtask

    // Line must sit idle for n cycles, checked on both clock edges.
    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_3125);
            #1;
            chk("idle_tx_pos", 32'(tx), 32'd1);
            chk("idle_done", 32'(tx_done), 32'd0);
            @(negedge clk_3125);
            chk("idle_tx_neg", 32'(tx), 32'd1);
        end
    endtask

    // Request one frame and check every cycle of it against the model.
    // hold    : keep tx_start high through the frame (continuous request)
    // disturb : scramble tx_start/data/parity_type during the data bits
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input bit hold, input bit disturb);
        logic fr [NBITS];
        // Frame model: start, data MSB first, parity, stop.
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1 + i] = d[7 - i];
        fr[9]  = (^d) ^ p;
        fr[10] = 1'b1;

        @(negedge clk_3125);
        data        = d;
        parity_type = p;
        tx_start    = 1'b1;
        @(posedge clk_3125);                        // request edge
        for (int k = 0; k < FLEN; k++) begin
            #1;
            chk("frame_tx_pos", 32'(tx), 32'(fr[k / CPB]));
            chk("frame_done_lo", 32'(tx_done), 32'd0);
            @(negedge clk_3125);
            chk("frame_tx_neg", 32'(tx), 32'(fr[k / CPB]));
            if (disturb && k >= 20 && k < 40) begin
                tx_start    = 1'($urandom_range(0, 1));
                data        = 8'($urandom);
                parity_type = 1'($urandom_range(0, 1));
            end else if (!hold) begin
                tx_start = 1'b0;
            end
            @(posedge clk_3125);
        end
        #1;
        chk("frame_done_hi", 32'(tx_done), 32'd1);
        chk("frame_tx_end", 32'(tx), 32'd1);
    endtask

    logic [7:0] b2b_tab [10];

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        tx_start    = 1'b1;
        data        = 8'h3C;
        parity_type = 1'b0;

        // Reset held with a pending request: line stays idle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_3125);
            #1;
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_done", 32'(tx_done), 32'd0);
        end
        @(negedge clk_3125);
        tx_start = 1'b0;
        rst_n    = 1'b1;
        idle_check(5);

        // Directed parity cases.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        idle_check(3);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        idle_check(3);
        send_frame(8'h01, 1'b0, 1'b0, 1'b0);
        idle_check(3);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        idle_check(3);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle_check(3);

        // Ten back-to-back frames, request re-asserted one cycle after tx_done.
        b2b_tab[0] = 8'hFF;
        b2b_tab[1] = 8'h00;
        b2b_tab[2] = 8'h81;
        for (int i = 3; i < 10; i++) b2b_tab[i] = 8'($urandom);
        for (int i = 0; i < 10; i++)
            send_frame(b2b_tab[i], 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle_check(4);

        // Request held high continuously: frames start the cycle after tx_done.
        send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle_check(4);

        // Inputs scrambled mid-frame: frame unaffected, no extra frame after.
        send_frame(8'hC6, 1'b1, 1'b0, 1'b1);
        @(negedge clk_3125);
        tx_start = 1'b0;
        idle_check(2 * CPB);

        // Reset during the data bits aborts the frame on that edge.
        @(negedge clk_3125);
        data        = 8'h00;
        parity_type = 1'b0;
        tx_start    = 1'b1;
        @(posedge clk_3125);
        @(negedge clk_3125);
        tx_start = 1'b0;
        repeat (50) @(negedge clk_3125);
        #1;
        chk("pre_abort_tx", 32'(tx), 32'd0);
        rst_n = 1'b0;
        @(posedge clk_3125);
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_done", 32'(tx_done), 32'd0);
        @(negedge clk_3125);
        rst_n = 1'b1;
        idle_check(FLEN + 10);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0);
        idle_check(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
